// File: rtl/fme_interp_pipe.sv
// ---------------------------------------------------------------------------
// fme_interp_pipe
//
// Fractional motion-estimation interpolation pipeline.  Each of NUM_CH lanes
// keeps an 8-row window of samples and applies one of four 8-tap filters
// (integer, 1/4, 1/2, 3/4 position).  The result is post-processed according
// to the pass mode:
//   LAST   : (S+32)>>>6, clipped to 0..255
//   FIRST  : S-8192, 16-bit signed, no clipping
//   SECOND : (S+526336)>>>12, clipped to 0..255
//
// Pipeline (3 registers, output visible 3 cycles after acceptance):
//   window/stage-1 -> partial sums (tap pairs) -> round/clip (output)
// A single enable en = !out_valid_o | out_ready_i advances every stage, the
// window and the fill counter, so a stalled output holds the whole pipe.
//
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   in_valid_i      : input beat valid
//   in_ready_o      : input beat accepted this cycle (== en)
//   in_sop_i        : first row of a block; restarts fill, latches frac/mode
//   in_frac_i       : filter select (0 int, 1 1/4, 2 1/2, 3 3/4)
//   in_mode_i       : pass mode (0 LAST, 1 FIRST, 2 SECOND, 3 -> LAST)
//   in_data_i       : NUM_CH samples, lane k at [k*IN_W +: IN_W]
//   out_valid_o     : output beat valid
//   out_ready_i     : downstream accepts output beat
//   out_data_o      : NUM_CH results, lane k at [k*16 +: 16]
// ---------------------------------------------------------------------------
module fme_interp_pipe #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_sop_i,
  input  logic [1:0]             in_frac_i,
  input  logic [1:0]             in_mode_i,
  input  logic [NUM_CH*IN_W-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NUM_CH*16-1:0]   out_data_o
);

  localparam int ACC_W = 25;
  localparam int TAPS  = 8;
  localparam int PAIRS = TAPS / 2;

  localparam logic [1:0] MODE_LAST   = 2'd0;
  localparam logic [1:0] MODE_FIRST  = 2'd1;
  localparam logic [1:0] MODE_SECOND = 2'd2;
  localparam logic [3:0] FILL_FULL   = 4'd8;

  localparam logic signed [ACC_W-1:0] RND_LAST   = 32;
  localparam logic signed [ACC_W-1:0] RND_SECOND = 526336;  // 2048 + 8192*64
  localparam logic signed [ACC_W-1:0] PIX_MAX    = 255;
  localparam logic [15:0]             OFS_FIRST  = 16'd8192;

  // Filter coefficients, indexed [frac][tap], tap0 = oldest row.
  localparam logic signed [7:0] COEF [4][TAPS] = '{
    '{ 8'sd0,  8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd4, -8'sd1},
    '{ 8'sd0,  8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd4, -8'sd1}
  };

  // 8-bit samples are unsigned pixels; wider samples are signed intermediates.
  function automatic logic signed [ACC_W-1:0] ext_sample(input logic [IN_W-1:0] x);
    logic sign_bit;
    sign_bit = (IN_W >= 16) ? x[IN_W-1] : 1'b0;
    return {{(ACC_W-IN_W){sign_bit}}, x};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_coef(input logic signed [7:0] c);
    return {{(ACC_W-8){c[7]}}, c};
  endfunction

  function automatic logic [15:0] clip_u8(input logic signed [ACC_W-1:0] v);
    logic [15:0] r;
    if (v[ACC_W-1]) begin
      r = 16'd0;
    end else if (v > PIX_MAX) begin
      r = 16'd255;
    end else begin
      r = {8'd0, v[7:0]};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Control: enable, fill counter, latched config, stage valid/config
  // ---------------------------------------------------------------------------
  logic       en;
  logic       accept;

  logic [3:0] fill_q, fill_d;
  logic [1:0] cfg_frac_q, cfg_frac_d;
  logic [1:0] cfg_mode_q, cfg_mode_d;
  logic       s1_valid_q, s1_valid_d;
  logic [1:0] s1_frac_q, s1_frac_d;
  logic [1:0] s1_mode_q, s1_mode_d;
  logic       s2_valid_q, s2_valid_d;
  logic [1:0] s2_mode_q, s2_mode_d;
  logic       out_valid_q, out_valid_d;

  assign en          = !out_valid_q || out_ready_i;
  assign accept      = in_valid_i && en;
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;

  always_comb begin
    fill_d      = fill_q;
    cfg_frac_d  = cfg_frac_q;
    cfg_mode_d  = cfg_mode_q;
    s1_valid_d  = s1_valid_q;
    s1_frac_d   = s1_frac_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    out_valid_d = out_valid_q;
    if (en) begin
      s1_valid_d = 1'b0;
      if (accept) begin
        if (in_sop_i) begin
          fill_d     = 4'd1;
          cfg_frac_d = in_frac_i;
          // Reserved mode 3 is folded into LAST here so later stages only
          // ever see three modes.
          cfg_mode_d = (in_mode_i == 2'd3) ? MODE_LAST : in_mode_i;
        end else if (fill_q != FILL_FULL) begin
          fill_d = fill_q + 4'd1;
        end
        // Config travels with the beat, so a later sop cannot touch it.
        s1_valid_d = (fill_d == FILL_FULL);
        s1_frac_d  = cfg_frac_d;
        s1_mode_d  = cfg_mode_d;
      end
      s2_valid_d  = s1_valid_q;
      s2_mode_d   = s1_mode_q;
      out_valid_d = s2_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q      <= 4'd0;
      cfg_frac_q  <= 2'd0;
      cfg_mode_q  <= MODE_LAST;
      s1_valid_q  <= 1'b0;
      s1_frac_q   <= 2'd0;
      s1_mode_q   <= MODE_LAST;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= MODE_LAST;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      cfg_frac_q  <= cfg_frac_d;
      cfg_mode_q  <= cfg_mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_frac_q   <= s1_frac_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane datapath: window -> pair partial sums -> round/clip
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [IN_W-1:0]         win_q [TAPS];
    logic [IN_W-1:0]         win_d [TAPS];
    logic signed [ACC_W-1:0] ps_q  [PAIRS];
    logic signed [ACC_W-1:0] ps_d  [PAIRS];
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd_last;
    logic signed [ACC_W-1:0] rnd_second;
    logic [15:0]             res_q, res_d;

    // Shift register: tap7 receives the newest row, tap0 holds the oldest.
    always_comb begin
      win_d = win_q;
      if (accept) begin
        for (int t = 0; t < TAPS - 1; t++) begin
          win_d[t] = win_q[t+1];
        end
        win_d[TAPS-1] = in_data_i[gi*IN_W +: IN_W];
      end
    end

    // Partial sums of adjacent tap pairs, using the config of the beat in
    // the window stage.
    always_comb begin
      ps_d = ps_q;
      if (en) begin
        for (int p = 0; p < PAIRS; p++) begin
          ps_d[p] = ext_sample(win_q[2*p])   * ext_coef(COEF[s1_frac_q][2*p]) +
                    ext_sample(win_q[2*p+1]) * ext_coef(COEF[s1_frac_q][2*p+1]);
        end
      end
    end

    always_comb begin
      sum        = ps_q[0] + ps_q[1] + ps_q[2] + ps_q[3];
      rnd_last   = (sum + RND_LAST) >>> 6;
      rnd_second = (sum + RND_SECOND) >>> 12;
      res_d      = res_q;
      if (en) begin
        case (s2_mode_q)
          // Modulo-2^16 subtraction equals truncating the full-width result.
          MODE_FIRST:  res_d = sum[15:0] - OFS_FIRST;
          MODE_SECOND: res_d = clip_u8(rnd_second);
          default:     res_d = clip_u8(rnd_last);
        endcase
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int t = 0; t < TAPS; t++) begin
          win_q[t] <= '0;
        end
        for (int p = 0; p < PAIRS; p++) begin
          ps_q[p] <= '0;
        end
        res_q <= 16'd0;
      end else begin
        win_q <= win_d;
        ps_q  <= ps_d;
        res_q <= res_d;
      end
    end

    assign out_data_o[gi*16 +: 16] = res_q;
  end

endmodule

// File: doc/fme_interp_pipe.md
FME_INTERP_PIPE -- requirements
Module: fme_interp_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of parallel filter lanes (1..16).
REQ-002 SHALL have parameter IN_W, default 8: sample width; 8 = unsigned pixel, zero-extended; 16 = signed intermediate.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1: input beat valid.
REQ-006 SHALL have port in_ready_o, output, 1: block accepts a beat this cycle.
REQ-007 SHALL have port in_sop_i, input, 1: beat is the first row of a new block; restarts the window and latches config.
REQ-008 SHALL have port in_frac_i, input, 2: fraction select, 0 = integer, 1 = 1/4, 2 = 1/2, 3 = 3/4; sampled only on an accepted sop beat.
REQ-009 SHALL have port in_mode_i, input, 2: pass mode, 0 = LAST, 1 = FIRST, 2 = SECOND, 3 = reserved and treated as LAST; sampled only on an accepted sop beat.
REQ-010 SHALL have port in_data_i, input, NUM_CH*IN_W: one row sample per lane; lane k in bits [k*IN_W +: IN_W].
REQ-011 SHALL have port out_valid_o, output, 1: output beat valid.
REQ-012 SHALL have port out_ready_i, input, 1: downstream accepts the output beat.
REQ-013 SHALL have port out_data_o, output, NUM_CH*16: one result per lane; lane k in bits [k*16 +: 16].

Function
REQ-014 SHALL keep, per lane, an 8-deep window shift register; tap0 is the oldest row and tap7 the newest; each accepted beat shifts in at tap7.
REQ-015 SHALL keep a fill counter, 0..8, saturating at 8: an accepted sop beat sets it to 1; any other accepted beat increments it.
REQ-016 SHALL emit one output beat per accepted input beat whose post-accept fill count equals 8; all other accepted beats produce no output.
REQ-017 SHALL use these coefficients, listed tap0..tap7:
  - frac 0: 0,0,0,64,0,0,0,0
  - frac 1: -1,4,-10,58,17,-5,1,0
  - frac 2: -1,4,-11,40,40,-11,4,-1
  - frac 3: 0,1,-5,17,58,-10,4,-1
REQ-018 SHALL compute the weighted sum S in a signed accumulator of at least 25 bits; no intermediate overflow is permitted.
REQ-019 SHALL produce the LAST-mode result as (S+32)>>>6, clipped to 0..255 and zero-extended to 16 bits.
REQ-020 SHALL produce the FIRST-mode result as S-8192, truncated to 16 bits signed, with no clipping.
REQ-021 SHALL produce the SECOND-mode result as (S+526336)>>>12, clipped to 0..255 and zero-extended to 16 bits.
REQ-022 SHALL use a 3-register pipeline: window register, partial-sum register (coefficient pairs summed), final round/clip register; an output appears on out_o in cycle t+3 after acceptance in cycle t when there is no stall.
REQ-023 SHALL carry frac, mode and valid with data through every stage; a sop accepted while beats are in flight SHALL NOT alter their results.
REQ-024 SHALL use a global enable en = !out_valid_o | out_ready_i; all stages, the window and the counter advance only when en is high; in_ready_o = en (combinational).
REQ-025 SHALL hold out_data_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0; no beat is lost or duplicated.
REQ-026 SHALL make a beat count as accepted only when in_valid_i & in_ready_o; in_data_i, in_sop_i and the config inputs are ignored otherwise.
REQ-027 SHALL treat beats arriving after reset without a prior sop as normal rows, using the reset config (frac 0, mode LAST).
REQ-028 SHALL let a sop beat arriving when fill is 8 reset fill to 1; a block shorter than 8 rows SHALL emit nothing.

Reset
REQ-029 SHALL, while rstn=0, immediately clear:
  - out_valid_o and all stage valid bits;
  - the fill counter, window registers, out_data_o and the latched frac/mode.
REQ-030 SHALL drive in_ready_o=1 during and after reset, because out_valid_o=0.
REQ-031 SHALL discard in-flight beats on reset mid-operation; after release, 8 new rows are needed before any output.

Verification
REQ-032 SHALL cover: NUM_CH=4, IN_W=8, sop with frac 2, mode 0, then 8 rows all 100 -> no output for rows 1-7; row 8 -> out 100 on every lane at t+3; row 9 of 100 -> another 100.
REQ-033 SHALL cover: frac 2, mode 1, rows 0,0,0,255,255,0,0,0 -> lane result 12208 (0x2FB0).
REQ-034 SHALL cover:
  - frac 1, mode 0, only tap2=255 -> S=-2550 -> out 0 (clipped);
  - frac 3, only tap4=255 -> out 231.
REQ-035 SHALL cover: IN_W=16, frac 2, mode 2, 8 rows all -1792 (0xF900) -> S=-114688 -> out 100.
REQ-036 SHALL cover backpressure: out_ready_i=0 for 3 cycles while valid -> in_ready_o=0, out_data_o stable; resume -> every expected beat delivered once, in order.
REQ-037 SHALL cover reset and sop:
  - rstn pulsed low mid-stream -> out_valid_o=0 asynchronously, fill=0;
  - sop with frac 0, mode 0 and 8 rows with row 4 = 77 -> out 77 (integer pass-through);
  - a sop accepted with 2 beats in flight -> those 2 beats finish with the old config.
